align_max_tracker: RTL and testbench
====================================

// Module: align_max_tracker
// PURPOSE
//  Consumes the per-cell score stream from the AlignScore cell array and finds the best
//  local-alignment score per subject sequence, with its query/subject coordinates.
//  Reports one result per subject over a valid/ready handshake to the hit reporter.
// PARAMETERS
//  SCORE_W  8   two's-complement score width (matches the cell array output)
//  QPOS_W   6   query position width (query length up to 2**QPOS_W)
//  SPOS_W   16  subject position counter width
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous, active-low reset
//  in_valid     in   1        score beat valid
//  in_ready     out  1        tracker accepts beat (beat transfers when valid & ready)
//  in_score     in   SCORE_W  signed cell score
//  in_qpos      in   QPOS_W   query index of this cell
//  in_last_col  in   1        last cell of current subject column (advance subject pos)
//  in_last      in   1        last cell of the subject (implies column end)
//  threshold    in   SCORE_W  signed hit threshold, sampled on first beat of each subject
//  res_valid    out  1        result valid
//  res_ready    in   1        downstream accepts result
//  res_score    out  SCORE_W  max score of subject
//  res_qpos     out  QPOS_W   query index of max
//  res_spos     out  SPOS_W   subject index of max
//  res_hit      out  1        res_score >= latched threshold (signed compare)
//  res_spos_sat out  1        subject counter saturated during this subject
// BEHAVIOUR
//  Reset (async, rst_n=0): state=ACCUM, in_ready=0 for first cycle after release then 1,
//   res_valid=0, res_score=most-negative, res_qpos=0, res_spos=0, res_hit=0, res_spos_sat=0.
//  FSM: ACCUM -> REPORT on accepted beat with in_last=1; REPORT -> ACCUM when res_valid&res_ready.
//  ACCUM: in_ready=1. Each accepted beat: if in_score > max (strict, signed) update max,
//   qpos, spos=current spos counter. Ties keep the earliest cell.
//  spos counter: +1 after an accepted beat with in_last_col=1; saturates at all-ones and
//   sets sat flag; never wraps. Cleared on entry to ACCUM.
//  First beat of a subject (first accept after reset/REPORT exit) latches threshold and
//   compares against max reset to most-negative, so a single-beat subject reports its score.
//  Latency: result registers valid the cycle after the in_last beat; res_valid=1 same cycle.
//  REPORT: in_ready=0; res_* held stable until handshake; res_hit computed at REPORT entry.
//  Simultaneous res_ready handshake and new in_valid: beat not accepted that cycle (in_ready=0);
//   accepted from the next cycle. One bubble per subject is the specified throughput.
//  in_last without in_last_col: treated as column end. in_qpos not range-checked.
//  rst_n asserted mid-subject or mid-REPORT: pending result discarded, all state cleared.
//  No arithmetic on scores besides signed compare; no overflow possible.
// STRUCTURE
//  Shared package (blastn_pkg): SCORE_W default, SCORE_MIN constant, 2-bit nucleotide codes,
//   FSM state encoding typedef {ACCUM, REPORT}.
//  One sub-module: score_max_cmp (combinational signed strict-greater compare + select).
//  FSM, spos counter, and result registers stay in this module.
// TESTING
//  1 Scores 3,-1,7,7,2 qpos 0..4, one column, in_last on beat 5, thr=5 -> res_score=7,
//    res_qpos=2, res_spos=0, res_hit=1, res_valid 1 cycle after last beat.
//  2 All scores -4, thr=0, 3 columns x 2 cells -> res_score=-4, qpos=0, spos=0, res_hit=0.
//  3 Max 9 in column 3 of 4, res_ready held 0 for 5 cycles -> res_* stable, in_ready=0 throughout,
//    in_valid beats not consumed; after handshake next subject starts with spos=0.
//  4 SPOS_W=2, 6 columns, max in column 5 -> res_spos=3, res_spos_sat=1.
//  5 Single beat score -128 (SCORE_W=8) with in_last -> res_score=-128, res_hit=1 when thr=-128.
//  6 rst_n low during REPORT, then new subject score 1 -> res_valid drops asynchronously;
//    next result res_score=1, no stale data.

Source files
------------

// File: rtl/blastn_pkg.sv
// Shared definitions for the BLASTN alignment datapath: score width, score floor,
// nucleotide codes and the max-tracker state encoding.
package blastn_pkg;

  localparam int SCORE_W_DEF = 8;
  localparam logic [SCORE_W_DEF-1:0] SCORE_MIN = {1'b1, {(SCORE_W_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    NT_A = 2'd0,
    NT_C = 2'd1,
    NT_G = 2'd2,
    NT_T = 2'd3
  } nt_code_e;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } trk_state_e;

endpackage

// File: rtl/score_max_cmp.sv
// Signed strict-greater compare of a new cell against the running maximum,
// selecting the winner's score and coordinates (ties keep the running max).
module score_max_cmp #(
  parameter int SCORE_W = 8,
  parameter int QPOS_W  = 6,
  parameter int SPOS_W  = 16
) (
  input  logic [SCORE_W-1:0] cur_score,
  input  logic [QPOS_W-1:0]  cur_qpos,
  input  logic [SPOS_W-1:0]  cur_spos,
  input  logic [SCORE_W-1:0] new_score,
  input  logic [QPOS_W-1:0]  new_qpos,
  input  logic [SPOS_W-1:0]  new_spos,
  output logic               greater,
  output logic [SCORE_W-1:0] sel_score,
  output logic [QPOS_W-1:0]  sel_qpos,
  output logic [SPOS_W-1:0]  sel_spos
);

  assign greater   = $signed(new_score) > $signed(cur_score);
  assign sel_score = greater ? new_score : cur_score;
  assign sel_qpos  = greater ? new_qpos  : cur_qpos;
  assign sel_spos  = greater ? new_spos  : cur_spos;

endmodule

// File: rtl/align_max_tracker.sv
// Tracks the best local-alignment score of each subject and its query/subject
// coordinates, reporting one result per subject over a valid/ready handshake.
module align_max_tracker
  import blastn_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF,
  parameter int QPOS_W  = 6,
  parameter int SPOS_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SCORE_W-1:0] in_score,
  input  logic [QPOS_W-1:0]  in_qpos,
  input  logic               in_last_col,
  input  logic               in_last,
  input  logic [SCORE_W-1:0] threshold,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [SCORE_W-1:0] res_score,
  output logic [QPOS_W-1:0]  res_qpos,
  output logic [SPOS_W-1:0]  res_spos,
  output logic               res_hit,
  output logic               res_spos_sat
);

  // state  | meaning
  // ACCUM  | consuming beats of the current subject, updating the running max
  // REPORT | result presented on res_*, waiting for res_ready

  localparam logic [SCORE_W-1:0] SMIN = {1'b1, {(SCORE_W-1){1'b0}}};

  trk_state_e         state, state_nxt;
  logic               ready_en;
  logic               first;
  logic [SCORE_W-1:0] max_score, thr;
  logic [QPOS_W-1:0]  max_qpos;
  logic [SPOS_W-1:0]  max_spos, spos_cnt;
  logic               sat, hit;
  logic               accept;
  logic [SCORE_W-1:0] base_score, nxt_score, thr_eff;
  logic [QPOS_W-1:0]  base_qpos, nxt_qpos;
  logic [SPOS_W-1:0]  base_spos, nxt_spos;
  logic               greater;

  // The first beat of a subject compares against a fresh floor, not the previous result.
  assign base_score = first ? SMIN : max_score;
  assign base_qpos  = first ? '0 : max_qpos;
  assign base_spos  = first ? '0 : max_spos;
  assign thr_eff    = first ? threshold : thr;
  assign accept     = in_valid & in_ready;

  score_max_cmp #(
    .SCORE_W(SCORE_W),
    .QPOS_W (QPOS_W),
    .SPOS_W (SPOS_W)
  ) u_cmp (
    .cur_score(base_score),
    .cur_qpos (base_qpos),
    .cur_spos (base_spos),
    .new_score(in_score),
    .new_qpos (in_qpos),
    .new_spos (spos_cnt),
    .greater  (greater),
    .sel_score(nxt_score),
    .sel_qpos (nxt_qpos),
    .sel_spos (nxt_spos)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = ready_en;
        if (in_valid && ready_en && in_last) state_nxt = REPORT;
      end
      REPORT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      ready_en  <= 1'b0;
      first     <= 1'b1;
      max_score <= SMIN;
      max_qpos  <= '0;
      max_spos  <= '0;
      spos_cnt  <= '0;
      thr       <= '0;
      sat       <= 1'b0;
      hit       <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
      if (accept) begin
        first     <= 1'b0;
        max_score <= nxt_score;
        max_qpos  <= nxt_qpos;
        max_spos  <= nxt_spos;
        if (first) thr <= threshold;
        // The final column's advance is moot: the counter clears when the result is taken.
        if (in_last_col && !in_last) begin
          if (&spos_cnt) sat <= 1'b1;
          else           spos_cnt <= spos_cnt + SPOS_W'(1);
        end
        if (in_last) hit <= $signed(nxt_score) >= $signed(thr_eff);
      end
      if (state == REPORT && res_ready) begin
        first    <= 1'b1;
        spos_cnt <= '0;
        sat      <= 1'b0;
      end
    end
  end

  assign res_score    = max_score;
  assign res_qpos     = max_qpos;
  assign res_spos     = max_spos;
  assign res_hit      = hit;
  assign res_spos_sat = sat;

endmodule

// File: tb/tb_align_max_tracker.sv
// Scoreboard bench for align_max_tracker: directed subjects plus randomized
// subjects checked against a per-subject reference model.
module tb_align_max_tracker;

  localparam int SW = 8;
  localparam int QW = 6;
  localparam int PW = 2;
  localparam int SPOS_MAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] in_score = '0;
  logic [QW-1:0] in_qpos = '0;
  logic          in_last_col = 1'b0;
  logic          in_last = 1'b0;
  logic [SW-1:0] threshold = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [SW-1:0] res_score;
  logic [QW-1:0] res_qpos;
  logic [PW-1:0] res_spos;
  logic          res_hit;
  logic          res_spos_sat;

  typedef struct {
    int score;
    int qpos;
    int spos;
    int hit;
    int sat;
  } res_t;

  typedef struct {
    int score;
    int qpos;
    bit lc;
    bit last;
  } beat_t;

  res_t  exp_q[$];
  beat_t subj[$];
  int    checks = 0;
  int    errors = 0;
  bit    rr_random = 1'b0;

  align_max_tracker #(.SCORE_W(SW), .QPOS_W(QW), .SPOS_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_score(in_score), .in_qpos(in_qpos),
    .in_last_col(in_last_col), .in_last(in_last), .threshold(threshold),
    .res_valid(res_valid), .res_ready(res_ready), .res_score(res_score),
    .res_qpos(res_qpos), .res_spos(res_spos), .res_hit(res_hit), .res_spos_sat(res_spos_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: best cell is the first one strictly above all earlier cells (floor = most negative);
  // subject index counts completed columns and sticks at its maximum.
  function automatic res_t model(input int thr);
    res_t r;
    int mx = -(1 << (SW-1));
    int q = 0, s = 0, col = 0;
    bit sat = 0;
    foreach (subj[i]) begin
      if (subj[i].score > mx) begin
        mx = subj[i].score;
        q = subj[i].qpos;
        s = (col > SPOS_MAX) ? SPOS_MAX : col;
      end
      if (subj[i].lc && !subj[i].last) begin
        col++;
        if (col > SPOS_MAX) sat = 1;
      end
    end
    r.score = mx; r.qpos = q; r.spos = s; r.hit = (mx >= thr) ? 1 : 0; r.sat = sat;
    return r;
  endfunction

  task automatic send_beat(input beat_t b);
    bit acc = 0;
    int n = 0;
    in_valid = 1'b1;
    in_score = SW'(b.score);
    in_qpos = QW'(b.qpos);
    in_last_col = b.lc;
    in_last = b.last;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        $display("FAIL beat_accept_timeout: in_ready stuck at %0d, required 1", in_ready);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
      end
    end
    in_valid = 1'b0;
    in_score = SW'($urandom);
    in_qpos = QW'($urandom);
    in_last_col = 1'($urandom);
    in_last = 1'($urandom);
  endtask

  task automatic send_subject(input int thr, input bit gaps);
    exp_q.push_back(model(thr));
    threshold = SW'(thr);
    foreach (subj[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_beat(subj[i]);
      if (i == 0) threshold = SW'($urandom);
    end
    chk("res_valid_latency", res_valid, 1);
  endtask

  task automatic add(input int score, input int qpos, input bit lc, input bit last);
    beat_t b;
    b.score = score; b.qpos = qpos; b.lc = lc; b.last = last;
    subj.push_back(b);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    chk("drain_pending_results", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: score %0d with no expected entry", $signed(res_score));
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("res_score", $signed(res_score), e.score);
        chk("res_qpos", res_qpos, e.qpos);
        chk("res_spos", res_spos, e.spos);
        chk("res_hit", res_hit, e.hit);
        chk("res_spos_sat", res_spos_sat, e.sat);
      end
    end
  end

  always @(posedge clk) begin
    if (rr_random) begin
      #1;
      if (rr_random) res_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_score", $signed(res_score), -128);
    chk("rst_res_qpos", res_qpos, 0);
    chk("rst_res_spos", res_spos, 0);
    chk("rst_res_hit", res_hit, 0);
    chk("rst_res_sat", res_spos_sat, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_first_cycle", in_ready, 0);
    @(posedge clk); #1;
    chk("in_ready_after_first", in_ready, 1);
    res_ready = 1'b1;

    // Scores 3,-1,7,7,2 in one column, threshold 5
    subj.delete();
    add(3, 0, 0, 0); add(-1, 1, 0, 0); add(7, 2, 0, 0); add(7, 3, 0, 0); add(2, 4, 1, 1);
    send_subject(5, 0);
    chk("t1_score", $signed(res_score), 7);
    chk("t1_qpos", res_qpos, 2);
    chk("t1_hit", res_hit, 1);

    // All -4, three columns of two cells, threshold 0
    subj.delete();
    for (int c = 0; c < 3; c++) begin
      add(-4, 0, 0, 0); add(-4, 1, 1, c == 2);
    end
    send_subject(0, 1);

    // Max 9 in column 3 of 4, result held back for 5 cycles with a beat waiting
    drain();
    res_ready = 1'b0;
    subj.delete();
    for (int c = 0; c < 4; c++) begin
      add((c == 2) ? 9 : c, 5, 0, 0); add((c == 2) ? 1 : 8, 6, 1, c == 3);
    end
    send_subject(3, 0);
    in_valid = 1'b1; in_score = 8'd6; in_qpos = 6'd1; in_last_col = 1'b1; in_last = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold_in_ready", in_ready, 0);
      chk("t3_hold_valid", res_valid, 1);
      chk("t3_hold_score", $signed(res_score), 9);
      chk("t3_hold_spos", res_spos, 2);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    subj.delete();
    add(6, 1, 1, 0); add(2, 0, 1, 1);
    send_subject(0, 0);

    // Subject counter saturation: six columns, max in fifth
    subj.delete();
    for (int c = 0; c < 6; c++) add((c == 4) ? 50 : -c, c, 1, c == 5);
    send_subject(10, 0);
    chk("t4_spos", res_spos, 3);
    chk("t4_sat", res_spos_sat, 1);

    // Single most-negative beat against most-negative threshold
    subj.delete();
    add(-128, 9, 0, 1);
    send_subject(-128, 0);
    chk("t5_score", $signed(res_score), -128);
    chk("t5_hit", res_hit, 1);

    // Reset during REPORT discards the pending result
    drain();
    res_ready = 1'b0;
    subj.delete();
    add(5, 7, 1, 1);
    send_subject(0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid_async_drop", res_valid, 0);
    chk("t6_score_cleared", $signed(res_score), -128);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_in_ready_first_cycle", in_ready, 0);
    res_ready = 1'b1;
    subj.delete();
    add(1, 3, 1, 1);
    send_subject(0, 0);
    chk("t6_new_score", $signed(res_score), 1);

    // Randomized subjects with random backpressure and input gaps
    drain();
    rr_random = 1'b1;
    for (int s = 0; s < 40; s++) begin
      int ncol, ncell, mode;
      ncol = $urandom_range(1, 6);
      mode = $urandom_range(0, 1);
      subj.delete();
      for (int c = 0; c < ncol; c++) begin
        ncell = $urandom_range(1, 3);
        for (int k = 0; k < ncell; k++) begin
          int sc;
          bit endc, lastb;
          sc = mode ? ($urandom_range(0, 255) - 128) : ($urandom_range(0, 6) - 3);
          endc = (k == ncell - 1);
          lastb = endc && (c == ncol - 1);
          add(sc, $urandom_range(0, 63), lastb ? 1'($urandom) : endc, lastb);
        end
      end
      send_subject($urandom_range(0, 255) - 128, 1);
    end
    rr_random = 1'b0;
    @(posedge clk); #2;
    res_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
